// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank writeback path: register geometry and
// the round-robin grant/pointer encoding.
package regbank_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_L = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=load. Grants are combinational;
// the pointer register prefers the side that lost the most recent grant.
module rr_arb2
  import regbank_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (!rst_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_q == GNT_A) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    // Hand preference to the side that was not just served.
    if (gnt_o[0]) begin
      ptr_d = GNT_L;
    end else if (gnt_o[1]) begin
      ptr_d = GNT_A;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= GNT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter sharing the register-bank write port between ALU and load results.
// Optional WBA_FORWARD_EN adds a combinational write-to-read bypass on two read ports.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              wba_clk,
  input  logic              wba_rst,
  input  logic              wba_a_valid,
  output logic              wba_a_ready,
  input  logic [ADDR_W-1:0] wba_a_addr,
  input  logic [DATA_W-1:0] wba_a_data,
  input  logic              wba_l_valid,
  output logic              wba_l_ready,
  input  logic [ADDR_W-1:0] wba_l_addr,
  input  logic [DATA_W-1:0] wba_l_data,
  output logic              wba_wr_en,
  output logic [ADDR_W-1:0] wba_wr_addr,
  output logic [DATA_W-1:0] wba_wr_data,
  output logic [CNT_W-1:0]  wba_conflicts,
`ifdef WBA_FORWARD_EN
  input  logic [ADDR_W-1:0] wba_rd_addr_1,
  input  logic [ADDR_W-1:0] wba_rd_addr_2,
  input  logic [DATA_W-1:0] wba_rf_out_1,
  input  logic [DATA_W-1:0] wba_rf_out_2,
  output logic [DATA_W-1:0] wba_fwd_out_1,
  output logic [DATA_W-1:0] wba_fwd_out_2,
`endif
  output logic              wba_busy
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [1:0]        gnt;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk_i (wba_clk),
    .rst_i (wba_rst),
    .req_i ({wba_l_valid, wba_a_valid}),
    .gnt_o (gnt)
  );

  assign wba_a_ready = gnt[0];
  assign wba_l_ready = gnt[1];

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    // Writes to x0 still consume the grant but never reach the bank.
    if (gnt[0]) begin
      wr_en_d   = (wba_a_addr != ZeroAddr);
      wr_addr_d = wba_a_addr;
      wr_data_d = wba_a_data;
    end else if (gnt[1]) begin
      wr_en_d   = (wba_l_addr != ZeroAddr);
      wr_addr_d = wba_l_addr;
      wr_data_d = wba_l_data;
    end
    if (wba_a_valid && wba_l_valid && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge wba_clk) begin
    if (wba_rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wba_wr_en     = wr_en_q;
  assign wba_wr_addr   = wr_addr_q;
  assign wba_wr_data   = wr_data_q;
  assign wba_conflicts = cnt_q;
  assign wba_busy      = wr_en_q;

`ifdef WBA_FORWARD_EN
  assign wba_fwd_out_1 = (wr_en_q && (wr_addr_q == wba_rd_addr_1) && (wba_rd_addr_1 != ZeroAddr))
                         ? wr_data_q : wba_rf_out_1;
  assign wba_fwd_out_2 = (wr_en_q && (wr_addr_q == wba_rd_addr_2) && (wba_rd_addr_2 != ZeroAddr))
                         ? wr_data_q : wba_rf_out_2;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter: directed vector table, saturation and
// reset sequences, randomized traffic against a reference model (WBA_FORWARD_EN optional).
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, l_valid;
  logic [4:0]  a_addr, l_addr;
  logic [31:0] a_data, l_data;
  logic        a_ready, l_ready, wr_en, busy;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conf;
  logic        s_a_ready, s_l_ready, s_wr_en, s_busy;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [3:0]  s_conf;
`ifdef WBA_FORWARD_EN
  logic [4:0]  rd_addr_1, rd_addr_2;
  logic [31:0] rf_out_1, rf_out_2, fwd_out_1, fwd_out_2, s_fwd_1, s_fwd_2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regbank_wb_arbiter dut (
    .wba_clk(clk), .wba_rst(rst),
    .wba_a_valid(a_valid), .wba_a_ready(a_ready), .wba_a_addr(a_addr), .wba_a_data(a_data),
    .wba_l_valid(l_valid), .wba_l_ready(l_ready), .wba_l_addr(l_addr), .wba_l_data(l_data),
    .wba_wr_en(wr_en), .wba_wr_addr(wr_addr), .wba_wr_data(wr_data), .wba_conflicts(conf),
`ifdef WBA_FORWARD_EN
    .wba_rd_addr_1(rd_addr_1), .wba_rd_addr_2(rd_addr_2),
    .wba_rf_out_1(rf_out_1), .wba_rf_out_2(rf_out_2),
    .wba_fwd_out_1(fwd_out_1), .wba_fwd_out_2(fwd_out_2),
`endif
    .wba_busy(busy)
  );

  // Narrow counter instance sharing the same stimulus, to reach saturation quickly.
  regbank_wb_arbiter #(.CNT_W(4)) dut_sat (
    .wba_clk(clk), .wba_rst(rst),
    .wba_a_valid(a_valid), .wba_a_ready(s_a_ready), .wba_a_addr(a_addr), .wba_a_data(a_data),
    .wba_l_valid(l_valid), .wba_l_ready(s_l_ready), .wba_l_addr(l_addr), .wba_l_data(l_data),
    .wba_wr_en(s_wr_en), .wba_wr_addr(s_wr_addr), .wba_wr_data(s_wr_data), .wba_conflicts(s_conf),
`ifdef WBA_FORWARD_EN
    .wba_rd_addr_1(rd_addr_1), .wba_rd_addr_2(rd_addr_2),
    .wba_rf_out_1(rf_out_1), .wba_rf_out_2(rf_out_2),
    .wba_fwd_out_1(s_fwd_1), .wba_fwd_out_2(s_fwd_2),
`endif
    .wba_busy(s_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic ea; logic el;
    logic ew; logic [4:0] ewa; logic [31:0] ewd; logic chk_ad;
    int   ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic lv, logic [4:0] la, logic [31:0] ld, logic ea, logic el,
                              logic ew, logic [4:0] ewa, logic [31:0] ewd, logic chk_ad, int ec);
    vec_t v;
    v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.ea = ea; v.el = el; v.ew = ew; v.ewa = ewa; v.ewd = ewd; v.chk_ad = chk_ad; v.ec = ec;
    return v;
  endfunction

  // Reference model: side numbers 0=none, 1=ALU, 2=load.
  int          last_w;
  int          m_cnt, m_cnt4;
  logic        m_wr_en;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic int pick(logic r, logic va, logic vl);
    if (r) return 0;
    if (va && vl) return (last_w == 1) ? 2 : 1;
    if (va) return 1;
    if (vl) return 2;
    return 0;
  endfunction

  task automatic model_edge(input int w);
    if (rst) begin
      last_w = 2; m_cnt = 0; m_cnt4 = 0; m_wr_en = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      if (a_valid && l_valid) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_wr_en = 1'b0;
      if (w == 1) begin
        m_wr_en = (a_addr != 0); m_wa = a_addr; m_wd = a_data; last_w = 1;
      end else if (w == 2) begin
        m_wr_en = (l_addr != 0); m_wa = l_addr; m_wd = l_data; last_w = 2;
      end
    end
  endtask

  task automatic set_in(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    rst = r; a_valid = av; a_addr = aa; a_data = ad; l_valid = lv; l_addr = la; l_data = ld;
  endtask

  initial begin
    logic a_hold, l_hold;
    int   w;
`ifdef WBA_FORWARD_EN
    rd_addr_1 = '0; rd_addr_2 = '0; rf_out_1 = '0; rf_out_2 = '0;
`endif
    // Reset state, with both requesters valid to show ready stays low.
    set_in(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    chk("reset a_ready", a_ready, 0);
    chk("reset l_ready", l_ready, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset conflicts", conf, 0);

    tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 0, 1, 5, 32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 5, 32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 3, 32'h11, 1, 4, 32'h22,       1, 0, 1, 3, 32'h11, 1, 1));
    tbl.push_back(mk(0, 1, 3, 32'h11, 1, 4, 32'h22,       0, 1, 1, 4, 32'h22, 1, 2));
    tbl.push_back(mk(0, 1, 3, 32'h11, 1, 4, 32'h22,       1, 0, 1, 3, 32'h11, 1, 3));
    tbl.push_back(mk(0, 1, 3, 32'h11, 1, 4, 32'h22,       0, 1, 1, 4, 32'h22, 1, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,      0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 6, 32'h66, 1, 8, 32'h88,       1, 0, 1, 6, 32'h66, 1, 5));
    tbl.push_back(mk(0, 1, 7, 32'h77, 0, 0, 0,            1, 0, 1, 7, 32'h77, 1, 5));
    tbl.push_back(mk(1, 1, 7, 32'h77, 0, 0, 0,            0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 32'hA1, 1, 2, 32'hB2,       1, 0, 1, 1, 32'hA1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 1, 32'hA1, 1, 1));
    tbl.push_back(mk(0, 1, 10, 32'h100, 1, 10, 32'h200,   0, 1, 1, 10, 32'h200, 1, 2));
    tbl.push_back(mk(0, 1, 10, 32'h100, 0, 0, 0,          1, 0, 1, 10, 32'h100, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 10, 32'h100, 1, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      set_in(tbl[i].rst, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].lv, tbl[i].la, tbl[i].ld);
      #1;
      chk($sformatf("v%0d a_ready", i), a_ready, tbl[i].ea);
      chk($sformatf("v%0d l_ready", i), l_ready, tbl[i].el);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wr_en", i), wr_en, tbl[i].ew);
      chk($sformatf("v%0d busy", i), busy, tbl[i].ew);
      if (tbl[i].chk_ad) begin
        chk($sformatf("v%0d wr_addr", i), wr_addr, tbl[i].ewa);
        chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].ewd);
      end
      chk($sformatf("v%0d conflicts", i), conf, tbl[i].ec);
    end

    // Saturation: 20 cycles with both valid after reset.
    @(negedge clk);
    set_in(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      @(posedge clk);
      #1;
      if (i == 14) chk("sat conflicts at 15", s_conf, 15);
    end
    chk("sat conflicts held at 15", s_conf, 15);
    chk("wide conflicts at 20", conf, 20);

    // Randomized traffic against the model.
    a_hold = 1'b0;
    l_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = (i == 0) || ($urandom_range(0, 39) == 0);
      if (!a_hold) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        a_data  = $urandom;
      end
      if (!l_hold) begin
        l_valid = ($urandom_range(0, 2) != 0);
        l_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        l_data  = $urandom;
      end
      #1;
      w = pick(rst, a_valid, l_valid);
      if (i > 0) begin
        chk("rand a_ready", a_ready, (w == 1));
        chk("rand l_ready", l_ready, (w == 2));
      end
      @(posedge clk);
      model_edge(w);
      #1;
      a_hold = a_valid && (w != 1);
      l_hold = l_valid && (w != 2);
      chk("rand wr_en", wr_en, m_wr_en);
      chk("rand busy", busy, m_wr_en);
      if (m_wr_en) begin
        chk("rand wr_addr", wr_addr, m_wa);
        chk("rand wr_data", wr_data, m_wd);
      end
      chk("rand conflicts", conf, m_cnt);
      chk("rand conflicts narrow", s_conf, m_cnt4);
    end

`ifdef WBA_FORWARD_EN
    @(negedge clk);
    set_in(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    set_in(1'b0, 1'b1, 5'd9, 32'h1234, 1'b0, 0, 0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    rd_addr_1 = 5'd9; rf_out_1 = 32'h0; rd_addr_2 = 5'd0; rf_out_2 = 32'hCAFE;
    #1;
    chk("fwd wr_en", wr_en, 1);
    chk("fwd out_1 bypass", fwd_out_1, 32'h1234);
    chk("fwd out_2 x0", fwd_out_2, 32'hCAFE);
    rd_addr_1 = 5'd3; rf_out_1 = 32'h5555;
    #1;
    chk("fwd out_1 other addr", fwd_out_1, 32'h5555);
    @(posedge clk);
    #1;
    rd_addr_1 = 5'd9; rf_out_1 = 32'h1234;
    #1;
    chk("fwd out_1 after write", fwd_out_1, 32'h1234);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
